// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI master among N_REQ requesters.
// Launches each granted word with a newd pulse and tracks the transfer through the master's cs line.
module spi_req_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DW       = 12,
    parameter int unsigned START_TO = 64,
    parameter int unsigned END_TO   = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic                err,
    output logic                busy,
    output logic                newd,
    output logic [DW-1:0]       din,
    input  logic                cs_mon
);

    localparam int unsigned IdxW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntMax = (START_TO > END_TO) ? START_TO : END_TO;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] StartLast = CntW'(START_TO - 1);
    localparam logic [CntW-1:0] EndLast   = CntW'(END_TO - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(N_REQ - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitStart,
        StWaitEnd,
        StComplete
    } state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [DW-1:0]    din_q, din_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             err_flag_q, err_flag_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             newd_q, newd_d;

    logic             win_vld;
    logic [IdxW-1:0]  win_idx;
    logic [IdxW-1:0]  cand;
    logic [DW-1:0]    win_data;

    // Scan ptr, ptr+1, ... and keep the first asserted request.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % N_REQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (IdxW'(k) == win_idx) begin
                win_data = req_data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        din_d      = din_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;

        case (state_q)
            StIdle: begin
                if (win_vld) begin
                    idx_d   = win_idx;
                    din_d   = win_data;
                    cnt_d   = '0;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                state_d = StWaitStart;
            end
            StWaitStart: begin
                if (!cs_mon) begin
                    cnt_d   = '0;
                    state_d = StWaitEnd;
                end else if (cnt_q == StartLast) begin
                    err_flag_d = 1'b1;
                    state_d    = StComplete;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitEnd: begin
                // A cs rise on the final count still wins over the timeout.
                if (cs_mon) begin
                    state_d = StComplete;
                end else if (cnt_q == EndLast) begin
                    err_flag_d = 1'b1;
                    state_d    = StComplete;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StComplete: begin
                err_flag_d = 1'b0;
                ptr_d      = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so each is a clean Moore pulse.
    always_comb begin
        newd_d = (state_d == StLaunch);
        gnt_d  = (state_d == StLaunch) ? (N_REQ'(1) << idx_d) : '0;
        ack_d  = (state_d == StComplete) ? (N_REQ'(1) << idx_d) : '0;
        err_d  = (state_d == StComplete) && err_flag_d;
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            idx_q      <= '0;
            din_q      <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            gnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            newd_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            din_q      <= din_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            newd_q     <= newd_d;
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign newd = newd_q;
    assign din  = din_q;

endmodule
